// File: rtl/spi_flash_pkg.sv
// -----------------------------------------------------------------------------
// spi_flash_pkg
// Shared definitions for the SPI flash command master: flash opcodes, the
// status-register busy bit position and the sequencer state encoding.
// No ports.
// -----------------------------------------------------------------------------
package spi_flash_pkg;

    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam int         WIP_BIT  = 0;

    typedef enum logic [2:0] {
        IDLE,
        WREN,
        GAP,
        RDSR_CMD,
        RDSR_READ,
        FINISH
    } spi_mst_state_t;

endpackage

// File: rtl/spi_flash_cmd_master_if.sv
// -----------------------------------------------------------------------------
// spi_flash_cmd_master_if
// Bundles the front-end handshake (start/busy/done/flag_end/status/timeout)
// and the single-lane SPI pins (CS/CLOCK/IO0/IO1) of the command master.
// Modports:
//   master - the command master: drives handshake results and SPI pins,
//            receives start and IO1.
//   slave  - the environment (front end + flash): drives start and IO1.
// -----------------------------------------------------------------------------
interface spi_flash_cmd_master_if;

    logic       start;
    logic       busy;
    logic       done;
    logic       flag_end;
    logic [7:0] status;
    logic       timeout;
    logic       CS;
    logic       CLOCK;
    logic       IO0;
    logic       IO1;

    modport master (
        input  start, IO1,
        output busy, done, flag_end, status, timeout, CS, CLOCK, IO0
    );

    modport slave (
        output start, IO1,
        input  busy, done, flag_end, status, timeout, CS, CLOCK, IO0
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen
// SPI mode-0 serial clock generator. While en is high, sclk toggles every
// CLK_DIV ACLK cycles starting low; while en is low sclk is held low and the
// divider is reloaded so the next frame starts with a full low half-period.
// Ports:
//   ACLK, ARESET - clock, async active-high reset
//   en           - frame active
//   sclk         - serial clock output (idles low)
//   rise_stb     - high in the ACLK cycle whose closing edge raises sclk
//   fall_stb     - high in the ACLK cycle whose closing edge lowers sclk
// -----------------------------------------------------------------------------
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          tc;

    assign tc       = en && (cnt_q == '0);
    assign rise_stb = tc && !sclk;
    assign fall_stb = tc && sclk;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt_q <= RELOAD;
            sclk  <= 1'b0;
        end else if (!en) begin
            cnt_q <= RELOAD;
            sclk  <= 1'b0;
        end else if (tc) begin
            cnt_q <= RELOAD;
            sclk  <= ~sclk;
        end else begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/spi_flash_cmd_master.sv
// -----------------------------------------------------------------------------
// spi_flash_cmd_master
// Sends Write-Enable, then Read-Status-Register to the external flash and
// keeps reading status bytes in the same CS-low frame until WIP clears.
// Parameters:
//   CLK_DIV  - ACLK cycles per SCLK half-period (>= 1)
//   MAX_POLL - status bytes read before giving up (1..255), only present
//              when SPI_FLASH_TIMEOUT_EN is defined
// Build option:
//   SPI_FLASH_TIMEOUT_EN - enables the saturating poll counter and timeout.
//                          Without it polling is unbounded and timeout is 0.
// Ports:
//   ACLK, ARESET - clock, async active-high reset
//   bus          - master modport: start/busy/done/flag_end/status/timeout
//                  and SPI pins CS/CLOCK/IO0/IO1
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | CS high, waiting for start
// WREN      | CS low, shifting opcode 0x06
// GAP       | CS high for 2*CLK_DIV cycles between the two frames
// RDSR_CMD  | CS low, shifting opcode 0x05
// RDSR_READ | CS low, reading status bytes back-to-back, IO0 held 0
// FINISH    | CS high, pulse done / set flag_end on the way back to IDLE
// -----------------------------------------------------------------------------
module spi_flash_cmd_master
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 4
`ifdef SPI_FLASH_TIMEOUT_EN
    ,
    parameter int MAX_POLL = 255
`endif
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    spi_flash_cmd_master_if.master bus
);

    localparam int               GAP_W    = $clog2(2 * CLK_DIV);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(2 * CLK_DIV - 1);
`ifdef SPI_FLASH_TIMEOUT_EN
    localparam logic [7:0]       POLL_MAX = 8'(MAX_POLL);
`endif

    spi_mst_state_t   state_q, state_d;

    logic             cs_q, cs_d;
    logic             io0_q, io0_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             flag_end_q, flag_end_d;
    logic [7:0]       status_q, status_d;
    logic [7:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`ifdef SPI_FLASH_TIMEOUT_EN
    logic             timeout_q, timeout_d;
    logic [7:0]       poll_cnt_q, poll_cnt_d;
    logic [7:0]       poll_next;
`endif

    logic             sclk;
    logic             rise_stb;
    logic             fall_stb;

    // The serial clock runs exactly while CS is low, so a frame always opens
    // with a full low half-period carrying the first bit.
    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .en       (!cs_q),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

`ifdef SPI_FLASH_TIMEOUT_EN
    assign poll_next = (poll_cnt_q == POLL_MAX) ? poll_cnt_q : poll_cnt_q + 8'd1;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        io0_d      = io0_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        flag_end_d = flag_end_q;
        status_d   = status_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
`ifdef SPI_FLASH_TIMEOUT_EN
        timeout_d  = timeout_q;
        poll_cnt_d = poll_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = WREN;
                    busy_d     = 1'b1;
                    flag_end_d = 1'b0;
                    cs_d       = 1'b0;
                    io0_d      = CMD_WREN[7];
                    tx_sr_d    = {CMD_WREN[6:0], 1'b0};
                    bit_cnt_d  = 3'd0;
`ifdef SPI_FLASH_TIMEOUT_EN
                    timeout_d  = 1'b0;
                    poll_cnt_d = 8'd0;
`endif
                end
            end

            WREN, RDSR_CMD: begin
                // Next bit goes out on the falling edge; after the 8th falling
                // edge the opcode is complete.
                if (fall_stb) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        io0_d = 1'b0;
                        if (state_q == WREN) begin
                            state_d   = GAP;
                            cs_d      = 1'b1;
                            gap_cnt_d = GAP_LOAD;
                        end else begin
                            state_d = RDSR_READ;
                        end
                    end else begin
                        io0_d   = tx_sr_q[7];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end
            end

            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d   = RDSR_CMD;
                    cs_d      = 1'b0;
                    io0_d     = CMD_RDSR[7];
                    tx_sr_d   = {CMD_RDSR[6:0], 1'b0};
                    bit_cnt_d = 3'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            RDSR_READ: begin
                if (rise_stb) begin
                    rx_sr_d = {rx_sr_q[6:0], bus.IO1};
                end
                // Byte boundary is the 8th falling edge: all 8 bits were
                // captured on the preceding rising edges.
                if (fall_stb) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        status_d = rx_sr_q;
`ifdef SPI_FLASH_TIMEOUT_EN
                        poll_cnt_d = poll_next;
`endif
                        if (!rx_sr_q[WIP_BIT]) begin
                            state_d = FINISH;
                            cs_d    = 1'b1;
                        end
`ifdef SPI_FLASH_TIMEOUT_EN
                        else if (poll_next == POLL_MAX) begin
                            state_d   = FINISH;
                            cs_d      = 1'b1;
                            timeout_d = 1'b1;
                        end
`endif
                    end
                end
            end

            FINISH: begin
                state_d    = IDLE;
                done_d     = 1'b1;
                flag_end_d = 1'b1;
                busy_d     = 1'b0;
            end

            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                io0_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cs_q       <= 1'b1;
            io0_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            flag_end_q <= 1'b0;
            status_q   <= 8'h00;
            tx_sr_q    <= 8'h00;
            rx_sr_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            gap_cnt_q  <= '0;
`ifdef SPI_FLASH_TIMEOUT_EN
            timeout_q  <= 1'b0;
            poll_cnt_q <= 8'd0;
`endif
        end else begin
            cs_q       <= cs_d;
            io0_q      <= io0_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            flag_end_q <= flag_end_d;
            status_q   <= status_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef SPI_FLASH_TIMEOUT_EN
            timeout_q  <= timeout_d;
            poll_cnt_q <= poll_cnt_d;
`endif
        end
    end

    assign bus.CS       = cs_q;
    assign bus.CLOCK    = sclk;
    assign bus.IO0      = io0_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.flag_end = flag_end_q;
    assign bus.status   = status_q;
`ifdef SPI_FLASH_TIMEOUT_EN
    assign bus.timeout  = timeout_q;
`else
    assign bus.timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_flash_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_cmd_master
// Bench for spi_flash_cmd_master with CLK_DIV=2. A behavioural flash model
// decodes MOSI, answers RDSR with a queue of status bytes and records frame
// and gap lengths; expected results come from the response queue alone.
// Build option SPI_FLASH_TIMEOUT_EN adds the timeout scenario (MAX_POLL=4).
// -----------------------------------------------------------------------------
module tb_spi_flash_cmd_master;

    localparam int D  = 2;
    localparam int MP = 4;

    logic ACLK;
    logic ARESET;

    spi_flash_cmd_master_if bus ();

    spi_flash_cmd_master #(
        .CLK_DIV (D)
`ifdef SPI_FLASH_TIMEOUT_EN
        ,
        .MAX_POLL (MP)
`endif
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_bad = 0;

    // flash model state
    logic [7:0] resp_q[$];
    logic       prev_cs, prev_clk, prev_io0, is_rdsr;
    logic [7:0] cur_byte, f1_byte, f2_byte;
    int         nframes, frame_len, frame_rises, gap_cnt;
    int         f1_len, f2_len, gap_len, bytes_read, read_nonzero, io0_glitch;

    // run observations
    int         done_cyc, ndone;
    logic       busy1, flag1, pre_flag, busy_at_done, flag_at_done, to_at_done;
    logic [7:0] status_at_done;

    function automatic logic [7:0] resp_at(input int i);
        if (resp_q.size() == 0) return 8'h00;
        if (i < resp_q.size()) return resp_q[i];
        return resp_q[resp_q.size() - 1];
    endfunction

    function automatic int exp_n();
        logic [7:0] b;
        int n;
        n = 1;
        for (int i = 0; i < 64; i++) begin
            b = resp_at(i);
            n = i + 1;
            if (b[0] == 1'b0) break;
`ifdef SPI_FLASH_TIMEOUT_EN
            if (n == MP) break;
`endif
        end
        return n;
    endfunction

    function automatic logic exp_timeout();
`ifdef SPI_FLASH_TIMEOUT_EN
        logic [7:0] b;
        b = resp_at(exp_n() - 1);
        return b[0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_done_cyc();
        return 50 * D + 2 + 16 * D * (exp_n() - 1);
    endfunction

    // Flash model, evaluated on the falling ACLK edge.
    always @(negedge ACLK) begin
        if (ARESET) begin
            prev_cs  = 1'b1;
            prev_clk = 1'b0;
            prev_io0 = 1'b0;
            is_rdsr  = 1'b0;
            bus.IO1  = 1'b0;
        end else begin
            if (!bus.CS) begin
                if (prev_cs) begin
                    nframes++;
                    if (nframes == 2) gap_len = gap_cnt;
                    frame_len   = 0;
                    frame_rises = 0;
                    cur_byte    = 8'h00;
                    is_rdsr     = 1'b0;
                end
                frame_len++;
                if (prev_clk && bus.CLOCK && (bus.IO0 !== prev_io0)) io0_glitch++;
                if (bus.CLOCK && !prev_clk) begin
                    cur_byte = {cur_byte[6:0], bus.IO0};
                    frame_rises++;
                    if (frame_rises % 8 == 0) begin
                        if (frame_rises == 8) begin
                            if (nframes == 1) f1_byte = cur_byte;
                            if (nframes == 2) f2_byte = cur_byte;
                            is_rdsr = (cur_byte == 8'h05);
                        end else if (cur_byte != 8'h00) begin
                            read_nonzero++;
                        end
                    end
                end
                if (!bus.CLOCK && prev_clk && is_rdsr && frame_rises >= 8) begin
                    cur_byte = resp_at((frame_rises - 8) / 8);
                    bus.IO1  = cur_byte[7 - ((frame_rises - 8) % 8)];
                    cur_byte = 8'h00;
                end
            end else begin
                if (!prev_cs) begin
                    gap_cnt = 0;
                    if (nframes == 1) f1_len = frame_len;
                    if (nframes == 2) begin
                        f2_len     = frame_len;
                        bytes_read = (frame_rises - 8) / 8;
                    end
                end
                gap_cnt++;
            end
            prev_cs  = bus.CS;
            prev_clk = bus.CLOCK;
            prev_io0 = bus.IO0;
        end
    end

    task automatic clear_obs();
        nframes = 0; f1_len = 0; f2_len = 0; gap_len = 0; bytes_read = 0;
        f1_byte = 8'h00; f2_byte = 8'h00; read_nonzero = 0; io0_glitch = 0;
        done_cyc = 0; ndone = 0; busy1 = 1'b0; flag1 = 1'b1;
        busy_at_done = 1'b1; flag_at_done = 1'b0; to_at_done = 1'b0;
        status_at_done = 8'h00;
    endtask

    // Pulses start and watches for a bounded number of cycles; cycle 1 is the
    // cycle after start is sampled. An extra start is injected at inj_cyc.
    task automatic do_run(input int inj_cyc, input int limit);
        int cyc;
        @(posedge ACLK);
        #1 clear_obs();
        @(negedge ACLK);
        pre_flag  = bus.flag_end;
        bus.start = 1'b1;
        @(posedge ACLK);
        cyc = 1;
        while (cyc <= limit) begin
            @(negedge ACLK);
            bus.start = (cyc == inj_cyc);
            if (cyc == 1) begin
                busy1 = bus.busy;
                flag1 = bus.flag_end;
            end
            if (bus.done) begin
                ndone++;
                if (done_cyc == 0) begin
                    done_cyc       = cyc;
                    busy_at_done   = bus.busy;
                    flag_at_done   = bus.flag_end;
                    to_at_done     = bus.timeout;
                    status_at_done = bus.status;
                end
            end
            @(posedge ACLK);
            cyc++;
        end
        #1 bus.start = 1'b0;
    endtask

    task automatic test_reset();
        ARESET    = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge ACLK);
        n_cmp++;
        if ({bus.CS, bus.CLOCK, bus.IO0, bus.busy, bus.done, bus.flag_end, bus.status, bus.timeout}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values: got cs=%b clk=%b io0=%b busy=%b done=%b fe=%b st=%h to=%b, expected 1 0 0 0 0 0 00 0",
                     bus.CS, bus.CLOCK, bus.IO0, bus.busy, bus.done, bus.flag_end, bus.status, bus.timeout);
        end
        ARESET = 1'b0;
        repeat (4) @(negedge ACLK);
        n_cmp++;
        if ({bus.CS, bus.CLOCK, bus.busy, bus.done} !== 4'b1000) begin
            n_bad++;
            $display("FAIL idle_after_reset: got cs/clk/busy/done=%b expected 1000",
                     {bus.CS, bus.CLOCK, bus.busy, bus.done});
        end
    endtask

    task automatic test_basic();
        resp_q = '{8'h00};
        do_run(0, exp_done_cyc() + 20);
        n_cmp++;
        if ({f1_byte, f2_byte} !== 16'h0605) begin
            n_bad++;
            $display("FAIL basic_opcodes: got %h %h expected 06 05", f1_byte, f2_byte);
        end
        n_cmp++;
        if (gap_len !== 2 * D || f1_len !== 16 * D || f2_len !== 32 * D) begin
            n_bad++;
            $display("FAIL basic_frame_timing: got f1=%0d gap=%0d f2=%0d expected %0d %0d %0d",
                     f1_len, gap_len, f2_len, 16 * D, 2 * D, 32 * D);
        end
        n_cmp++;
        if (done_cyc !== 102) begin
            n_bad++;
            $display("FAIL basic_done_cycle: got %0d expected 102", done_cyc);
        end
        n_cmp++;
        if ({status_at_done, busy1, busy_at_done, flag_at_done, ndone[3:0]} !== {8'h00, 1'b1, 1'b0, 1'b1, 4'd1}) begin
            n_bad++;
            $display("FAIL basic_handshake: got st=%h busy1=%b busy_done=%b fe=%b ndone=%0d expected 00 1 0 1 1",
                     status_at_done, busy1, busy_at_done, flag_at_done, ndone);
        end
        n_cmp++;
        if (io0_glitch !== 0 || read_nonzero !== 0) begin
            n_bad++;
            $display("FAIL basic_mosi_rules: got glitches=%0d nonzero_read_mosi=%0d expected 0 0",
                     io0_glitch, read_nonzero);
        end
    endtask

    task automatic test_poll_sequence();
        resp_q = '{8'h03, 8'h03, 8'h02};
        do_run(0, exp_done_cyc() + 20);
        n_cmp++;
        if (bytes_read !== 3 || status_at_done !== 8'h02 || to_at_done !== 1'b0) begin
            n_bad++;
            $display("FAIL poll_sequence: got bytes=%0d st=%h to=%b expected 3 02 0",
                     bytes_read, status_at_done, to_at_done);
        end
        n_cmp++;
        if (done_cyc !== 50 * D + 2 + 32 * D) begin
            n_bad++;
            $display("FAIL poll_done_cycle: got %0d expected %0d", done_cyc, 50 * D + 2 + 32 * D);
        end
    endtask

    task automatic test_random();
        int nb;
        logic [7:0] b;
        for (int it = 0; it < 6; it++) begin
            nb = $urandom_range(0, 5);
            resp_q.delete();
            for (int j = 0; j < nb; j++) begin
                b = 8'($urandom_range(0, 255)) | 8'h01;
                resp_q.push_back(b);
            end
            b = 8'($urandom_range(0, 255)) & 8'hFE;
            resp_q.push_back(b);
            do_run(0, exp_done_cyc() + 20);
            b = resp_at(exp_n() - 1);
            n_cmp++;
            if (done_cyc !== exp_done_cyc() || ndone !== 1 || nframes !== 2) begin
                n_bad++;
                $display("FAIL random_%0d_timing: got done=%0d ndone=%0d frames=%0d expected %0d 1 2",
                         it, done_cyc, ndone, nframes, exp_done_cyc());
            end
            n_cmp++;
            if (status_at_done !== b || bytes_read !== exp_n() || to_at_done !== exp_timeout()) begin
                n_bad++;
                $display("FAIL random_%0d_status: got st=%h bytes=%0d to=%b expected %h %0d %b",
                         it, status_at_done, bytes_read, to_at_done, b, exp_n(), exp_timeout());
            end
            n_cmp++;
            if (bus.CS !== 1'b1 || bus.flag_end !== 1'b1 || io0_glitch !== 0) begin
                n_bad++;
                $display("FAIL random_%0d_idle: got cs=%b fe=%b glitches=%0d expected 1 1 0",
                         it, bus.CS, bus.flag_end, io0_glitch);
            end
        end
    endtask

    task automatic test_start_ignored();
        resp_q = '{8'h01, 8'h00};
        do_run(5, exp_done_cyc() + 40);
        n_cmp++;
        if (ndone !== 1 || nframes !== 2 || done_cyc !== exp_done_cyc()) begin
            n_bad++;
            $display("FAIL start_during_wren: got ndone=%0d frames=%0d done=%0d expected 1 2 %0d",
                     ndone, nframes, done_cyc, exp_done_cyc());
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        resp_q = '{8'h00};
        @(posedge ACLK);
        #1 clear_obs();
        @(negedge ACLK);
        bus.start = 1'b1;
        @(posedge ACLK);
        cyc = 1;
        @(negedge ACLK);
        bus.start = 1'b0;
        while (cyc < 25 * D + 1) begin
            @(posedge ACLK);
            cyc++;
            @(negedge ACLK);
        end
        n_cmp++;
        if ({bus.CS, bus.CLOCK, bus.busy} !== 3'b011) begin
            n_bad++;
            $display("FAIL rdsr_bit3_pre_reset: got cs/clk/busy=%b expected 011",
                     {bus.CS, bus.CLOCK, bus.busy});
        end
        ARESET = 1'b1;
        #1;
        n_cmp++;
        if ({bus.CS, bus.CLOCK, bus.busy, bus.IO0, bus.status} !== {4'b1000, 8'h00}) begin
            n_bad++;
            $display("FAIL async_reset_mid_frame: got cs=%b clk=%b busy=%b io0=%b st=%h expected 1 0 0 0 00",
                     bus.CS, bus.CLOCK, bus.busy, bus.IO0, bus.status);
        end
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        do_run(0, exp_done_cyc() + 20);
        n_cmp++;
        if (done_cyc !== 50 * D + 2 || {f1_byte, f2_byte} !== 16'h0605 || ndone !== 1) begin
            n_bad++;
            $display("FAIL run_after_reset: got done=%0d op=%h%h ndone=%0d expected %0d 0605 1",
                     done_cyc, f1_byte, f2_byte, ndone, 50 * D + 2);
        end
    endtask

    task automatic test_back_to_back();
        resp_q = '{8'h81, 8'h80};
        do_run(0, exp_done_cyc() + 20);
        resp_q = '{8'h40};
        do_run(0, exp_done_cyc() + 20);
        n_cmp++;
        if ({pre_flag, flag1, busy1} !== 3'b101) begin
            n_bad++;
            $display("FAIL flag_end_clear_on_start: got pre=%b cyc1=%b busy1=%b expected 1 0 1",
                     pre_flag, flag1, busy1);
        end
        n_cmp++;
        if (status_at_done !== 8'h40 || done_cyc !== 50 * D + 2) begin
            n_bad++;
            $display("FAIL back_to_back_second: got st=%h done=%0d expected 40 %0d",
                     status_at_done, done_cyc, 50 * D + 2);
        end
    endtask

`ifdef SPI_FLASH_TIMEOUT_EN
    task automatic test_timeout();
        resp_q = '{8'hFF};
        do_run(0, 50 * D + 2 + 16 * D * (MP - 1) + 20);
        n_cmp++;
        if (bytes_read !== MP || status_at_done !== 8'hFF || to_at_done !== 1'b1 || ndone !== 1) begin
            n_bad++;
            $display("FAIL timeout_maxpoll: got bytes=%0d st=%h to=%b ndone=%0d expected %0d FF 1 1",
                     bytes_read, status_at_done, to_at_done, ndone, MP);
        end
        n_cmp++;
        if (done_cyc !== 50 * D + 2 + 16 * D * (MP - 1) || flag_at_done !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_done: got done=%0d fe=%b expected %0d 1",
                     done_cyc, flag_at_done, 50 * D + 2 + 16 * D * (MP - 1));
        end
        resp_q = '{8'h00};
        do_run(0, exp_done_cyc() + 20);
        n_cmp++;
        if (to_at_done !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_cleared_by_start: got %b expected 0", to_at_done);
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        ARESET    = 1'b1;
        clear_obs();
        test_reset();
        test_basic();
        test_poll_sequence();
        test_random();
        test_start_ignored();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef SPI_FLASH_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_cmd_master.md
# spi_flash_cmd_master

SPI initiator that sends the Write-Enable / Read-Status-Register command sequence to the external QSPI flash and polls its status until the flash reports it is not busy. It sits on the controller side of the single-lane SPI link, opposite the flash memory model. It drives CS, SCLK and IO0 and samples the flash's status on IO1. It reports completion to the rest of the front end through `done` and `flag_end`.

## Interface
- `CLK_DIV`, default 4: ACLK cycles per SCLK half-period; minimum 1.
- `MAX_POLL`, default 255: maximum number of status bytes read before a timeout is declared. Only used with `SPI_FLASH_TIMEOUT_EN`.
- `ACLK` in 1: the only clock; all logic is on the rising edge.
- `ARESET` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to run the sequence.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse when the sequence ends.
- `flag_end` out 1: level; set together with `done`, cleared when the next `start` is accepted.
- `status` out 8: last status byte received from the flash.
- `timeout` out 1: sticky until the next `start`; the sequence ended without WIP clearing.
- `CS` out 1: flash chip select, active low.
- `CLOCK` out 1: SCLK; idles low (SPI mode 0).
- `IO0` out 1: MOSI, MSB first.
- `IO1` in 1: MISO.

## Operation
- Reset values: `CS`=1, `CLOCK`=0, `IO0`=0, `busy`=0, `done`=0, `flag_end`=0, `status`=8'h00, `timeout`=0. The state machine resets to IDLE.
- IDLE: `start`=1 is accepted. The block then sets `busy`, clears `flag_end` and `timeout`, and goes to WREN.
  - `start` while `busy` is ignored.
- WREN: `CS` low; shifts opcode 8'h06. On reaching 8 bits, goes to GAP.
- GAP: `CS` high for 2*CLK_DIV cycles, then goes to RDSR_CMD.
- RDSR_CMD: `CS` low; shifts opcode 8'h05, then goes to RDSR_READ.
- RDSR_READ: `CS` stays low; reads status bytes back-to-back and holds `IO0` at 0.
  - After each full byte, `status` is updated with that byte.
  - If bit 0 (WIP) is 0, go to FINISH.
  - Otherwise read another byte.
- FINISH: `CS` high. Pulses `done`, sets `flag_end`, clears `busy`, returns to IDLE.
- Bit handling: `IO0` changes only while `CLOCK` is low. `IO1` is sampled on the ACLK edge that raises `CLOCK`. Bits are shifted MSB first.
- Poll counter: 8 bits wide; saturates at MAX_POLL and never wraps.
- Reset mid-frame: all outputs return immediately (asynchronously) to their reset values. A partial `status` byte is discarded.

## Timing
- `start` sampled at cycle 0 → `CS` falls at cycle 1. With CLK_DIV=D:
  - Bit k (k = 0..7) is valid on `IO0` from cycle 1+2kD.
  - `CLOCK` is high during cycles [1+(2k+1)D, 1+(2k+2)D).
- A command frame is 16D cycles long. `CS` rises on the cycle after the last `CLOCK` falling edge.
- Each status byte adds 16D cycles. There is no `CS` or `CLOCK` gap between consecutive status bytes.
- `done` is asserted in the cycle after `CS` rises at the end of RDSR_READ.
- Minimum latency from `start` to `done` (first status byte already not busy): 1 + 16D + 2D + 32D + 1 = 50D+2 cycles.

## Configuration
- `SPI_FLASH_TIMEOUT_EN` defined:
  - When the MAX_POLL-th status byte still has WIP=1, the block goes to FINISH with `timeout`=1.
  - `done` still pulses and `flag_end` is still set.
- `SPI_FLASH_TIMEOUT_EN` not defined:
  - There is no poll counter and `timeout` is tied to 0.
  - RDSR_READ polls indefinitely until WIP=0 or reset.

## Structure
- Package `spi_flash_pkg`:
  - Opcodes `CMD_WREN`=8'h06 and `CMD_RDSR`=8'h05.
  - `WIP_BIT`=0.
  - State enum `spi_mst_state_t` {IDLE, WREN, GAP, RDSR_CMD, RDSR_READ, FINISH}.
- Sub-module `spi_sclk_gen`:
  - Parameterised by CLK_DIV; enabled while a frame is active.
  - Drives `CLOCK` and one-cycle `rise_stb`/`fall_stb` strobes.
  - Shift and sample logic in the top module uses only these strobes.

## Test plan
- CLK_DIV=2, `IO1` held 0. Pulse `start` → `IO0` carries 0x06 then 0x05, separated by a 4-cycle `CS`-high gap. `status`=8'h00 and `done` pulses at cycle 102.
- Flash returns 0x03, 0x03, then 0x02 → exactly 3 status bytes are read, final `status`=8'h02, `timeout`=0.
- With `SPI_FLASH_TIMEOUT_EN`, MAX_POLL=4, `IO1` held 1 → 4 bytes of 0xFF are read, then `timeout`=1, `done` pulses and `status`=8'hFF.
- Second `start` pulse during WREN → ignored; exactly one `done` pulse.
- `ARESET` asserted at bit 3 of RDSR_CMD → `CS`=1, `CLOCK`=0 and `busy`=0 in the same cycle. A later `start` runs the full sequence cleanly.
- Bench tied to the flash memory model with CLK_DIV=4 → `flag_end` rises after the model's status reads 0, and the model returns to idle.
